// File: rtl/cmd_framer.sv
// rtl/cmd_framer.sv - host command framer: 6-byte header parse, command handshake, load payload forwarding
//
// Parameters
//   ADDR_WIDTH      width of cmd_addr, 1..16 (low-memory address space)
//   TIMEOUT_CYCLES  idle cycles allowed between header bytes, 1..65535
//
// Ports
//   clk, rst                  system clock (rising edge), async active-high reset
//   in_data, in_empty         head byte / empty flag of the upstream receive fifo
//   in_read                   one-cycle pop strobe to the upstream fifo
//   cmd_valid, cmd_ready      command handshake; cmd_op/cmd_addr/cmd_len held while valid
//   pl_valid, pl_ready        load payload byte handshake, pl_data carries the byte
//   echo_valid, echo_data     copy of every consumed byte
//   err_opcode, err_timeout   one-cycle error pulses
//   busy                      high unless idle waiting for the first header byte
//
// Build option
//   CMD_FRAMER_ECHO_EN        when defined, echo_valid/echo_data mirror every pop;
//                             otherwise they are tied to zero.

module cmd_framer #(
    parameter int ADDR_WIDTH     = 13,
    parameter int TIMEOUT_CYCLES = 12000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_empty,
    output logic                  in_read,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [1:0]            cmd_op,
    output logic [ADDR_WIDTH-1:0] cmd_addr,
    output logic [15:0]           cmd_len,
    output logic                  pl_valid,
    input  logic                  pl_ready,
    output logic [7:0]            pl_data,
    output logic                  echo_valid,
    output logic [7:0]            echo_data,
    output logic                  err_opcode,
    output logic                  err_timeout,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_HDR,
        S_SETTLE,
        S_CMD,
        S_PAYLOAD
    } state_t;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]  HDR_BYTES  = 3'd6;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [2:0]  r_count;
    logic [1:0]  r_op;
    logic [7:0]  r_adr_hi;
    logic [7:0]  r_adr_lo;
    logic [7:0]  r_len_hi;
    logic [7:0]  r_len_lo;
    logic [15:0] r_remaining;
    logic [15:0] r_timer;
    logic        r_read_prev;
    logic        r_pl_valid;
    logic [7:0]  r_pl_data;

    logic        w_can_pop;
    logic        w_partial;
    logic [15:0] w_len;
    logic [15:0] w_addr16;
    logic        w_hdr_pop;
    logic        w_pl_pop;
    logic        w_pl_hs;
    logic        w_cmd_hs;
    logic        w_cmd_valid;
    logic        w_op_err;
    logic        w_timeout;

    // The fifo head is only trusted when the previous cycle did not pop,
    // giving the upstream fifo a cycle to present its next byte.
    assign w_can_pop = !in_empty && !r_read_prev;
    assign w_partial = (r_count != 3'd0) && (r_count < HDR_BYTES);
    assign w_len     = {r_len_hi, r_len_lo};
    assign w_addr16  = {r_adr_hi, r_adr_lo};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hdr_pop   = 1'b0;
        w_pl_pop    = 1'b0;
        w_pl_hs     = 1'b0;
        w_cmd_hs    = 1'b0;
        w_cmd_valid = 1'b0;
        w_op_err    = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_HDR: begin
                if (w_can_pop) begin
                    w_hdr_pop   = 1'b1;
                    w_state_nxt = S_SETTLE;
                end else if (w_partial && (r_timer >= TIMER_LAST)) begin
                    w_timeout = 1'b1;
                end
            end
            S_SETTLE: begin
                if (r_count == HDR_BYTES) begin
                    if (r_op == 2'd0) begin
                        w_op_err    = 1'b1;
                        w_state_nxt = S_HDR;
                    end else begin
                        w_state_nxt = S_CMD;
                    end
                end else begin
                    w_state_nxt = S_HDR;
                end
            end
            S_CMD: begin
                w_cmd_valid = 1'b1;
                if (cmd_ready) begin
                    w_cmd_hs = 1'b1;
                    if ((r_op == 2'd1) && (w_len != 16'd0)) begin
                        w_state_nxt = S_PAYLOAD;
                    end else begin
                        w_state_nxt = S_HDR;
                    end
                end
            end
            S_PAYLOAD: begin
                // Only one payload byte in flight: the next pop waits for
                // the current byte to be accepted downstream.
                if (!r_pl_valid && w_can_pop) begin
                    w_pl_pop = 1'b1;
                end
                if (r_pl_valid && pl_ready) begin
                    w_pl_hs = 1'b1;
                    if (r_remaining == 16'd1) begin
                        w_state_nxt = S_HDR;
                    end
                end
            end
            default: begin
                w_state_nxt = S_HDR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count     <= 3'd0;
            r_op        <= 2'd0;
            r_adr_hi    <= 8'h00;
            r_adr_lo    <= 8'h00;
            r_len_hi    <= 8'h00;
            r_len_lo    <= 8'h00;
            r_remaining <= 16'd0;
            r_timer     <= 16'd0;
            r_read_prev <= 1'b0;
            r_pl_valid  <= 1'b0;
            r_pl_data   <= 8'h00;
        end else begin
            r_read_prev <= in_read;

            if (w_hdr_pop) begin
                case (r_count)
                    3'd0:    r_op     <= in_data[1:0];
                    3'd2:    r_adr_hi <= in_data;
                    3'd3:    r_adr_lo <= in_data;
                    3'd4:    r_len_hi <= in_data;
                    3'd5:    r_len_lo <= in_data;
                    default: ;
                endcase
                r_count <= r_count + 3'd1;
            end else if (w_timeout || w_op_err || w_cmd_hs) begin
                r_count <= 3'd0;
            end

            // Counts cycles since the last header pop while a header is
            // half collected; idle, CMD and PAYLOAD keep it cleared.
            if (w_hdr_pop || !w_partial || w_timeout) begin
                r_timer <= 16'd0;
            end else if (r_timer != 16'hFFFF) begin
                r_timer <= r_timer + 16'd1;
            end

            if (w_cmd_hs) begin
                r_remaining <= w_len;
            end else if (w_pl_hs) begin
                r_remaining <= r_remaining - 16'd1;
            end

            if (w_pl_pop) begin
                r_pl_data  <= in_data;
                r_pl_valid <= 1'b1;
            end else if (w_pl_hs) begin
                r_pl_valid <= 1'b0;
            end
        end
    end

    // in_read depends on in_empty directly, so it is masked during reset
    // to keep every output low from the moment rst rises.
    assign in_read     = !rst && (w_hdr_pop || w_pl_pop);
    assign cmd_valid   = w_cmd_valid;
    assign cmd_op      = r_op;
    assign cmd_addr    = ADDR_WIDTH'(w_addr16);
    assign cmd_len     = w_len;
    assign pl_valid    = r_pl_valid;
    assign pl_data     = r_pl_data;
    assign err_opcode  = w_op_err;
    assign err_timeout = w_timeout;
    assign busy        = !((r_state == S_HDR) && (r_count == 3'd0));

`ifdef CMD_FRAMER_ECHO_EN
    assign echo_valid = in_read;
    assign echo_data  = in_read ? in_data : 8'h00;
`else
    assign echo_valid = 1'b0;
    assign echo_data  = 8'h00;
`endif

endmodule

// File: tb/tb_cmd_framer.sv
// tb/tb_cmd_framer.sv - self-checking bench for cmd_framer against a byte-stream reference model

module tb_cmd_framer;

    localparam int AW = 13;
    localparam int TO = 100;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_empty;
    logic          in_read;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [15:0]   cmd_len;
    logic          pl_valid;
    logic          pl_ready;
    logic [7:0]    pl_data;
    logic          echo_valid;
    logic [7:0]    echo_data;
    logic          err_opcode;
    logic          err_timeout;
    logic          busy;

    cmd_framer #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_empty   (in_empty),
        .in_read    (in_read),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .pl_valid   (pl_valid),
        .pl_ready   (pl_ready),
        .pl_data    (pl_data),
        .echo_valid (echo_valid),
        .echo_data  (echo_data),
        .err_opcode (err_opcode),
        .err_timeout(err_timeout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    byte unsigned fifo[$];
    logic [33:0]  obs_cmd[$];
    logic [33:0]  exp_cmd[$];
    byte unsigned obs_pl[$];
    byte unsigned exp_pl[$];
    int exp_errop, exp_pops;

    int n_pop, n_errop, n_errto, n_plhigh;
    int viol_rd, viol_cmd, viol_pl, viol_echo;
    bit pop_pending, prev_rd, prev_cmd_hold, prev_pl_hold;
    logic [33:0] prev_fields;
    byte unsigned prev_pl;
    int pl_hi_cnt;
    bit hs_pending;
    logic busy_after_pl;
    int cmd_pct = 100;
    int pl_pct  = 100;
    bit pl_mode = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic clear_obs();
        obs_cmd.delete();
        obs_pl.delete();
        n_pop = 0; n_errop = 0; n_errto = 0; n_plhigh = 0;
        viol_rd = 0; viol_cmd = 0; viol_pl = 0; viol_echo = 0;
        prev_rd = 0; prev_cmd_hold = 0; prev_pl_hold = 0;
        pl_hi_cnt = 0; hs_pending = 0; busy_after_pl = 1'b1;
    endtask

    task automatic drive();
        in_empty  = (fifo.size() == 0);
        in_data   = (fifo.size() == 0) ? 8'h00 : fifo[0];
        cmd_ready = ($urandom_range(0, 99) < cmd_pct);
        if (pl_mode) pl_ready = (pl_hi_cnt >= 5);
        else         pl_ready = ($urandom_range(0, 99) < pl_pct);
    endtask

    // One clock: observe outputs on the falling edge, then update the
    // upstream fifo and ready inputs just after the rising edge.
    task automatic tick();
        logic [33:0] cur;
        @(negedge clk);
        if (hs_pending) begin
            busy_after_pl = busy;
            hs_pending = 0;
        end
        if (in_read) begin
            n_pop++;
            if (prev_rd || fifo.size() == 0) viol_rd++;
            if (fifo.size() != 0) pop_pending = 1;
        end
        prev_rd = in_read;
`ifdef CMD_FRAMER_ECHO_EN
        if (echo_valid !== in_read) viol_echo++;
        if (in_read && echo_data !== in_data) viol_echo++;
`else
        if (echo_valid !== 1'b0 || echo_data !== 8'h00) viol_echo++;
`endif
        cur = {cmd_op, 16'(cmd_addr), cmd_len};
        if (prev_cmd_hold && (!cmd_valid || cur !== prev_fields)) viol_cmd++;
        if (cmd_valid && cmd_ready) obs_cmd.push_back(cur);
        prev_cmd_hold = cmd_valid && !cmd_ready;
        prev_fields   = cur;
        if (prev_pl_hold && (!pl_valid || pl_data !== prev_pl)) viol_pl++;
        if (pl_valid && pl_ready) begin
            obs_pl.push_back(pl_data);
            hs_pending = 1;
        end
        prev_pl_hold = pl_valid && !pl_ready;
        prev_pl      = pl_data;
        if (err_opcode)  n_errop++;
        if (err_timeout) n_errto++;
        if (pl_valid) begin
            n_plhigh++;
            pl_hi_cnt++;
        end else begin
            pl_hi_cnt = 0;
        end
        @(posedge clk);
        #1;
        if (pop_pending) begin
            fifo.delete(0);
            pop_pending = 0;
        end
        drive();
    endtask

    // Reference: walk the byte stream as a sequence of frames.
    task automatic model(input byte unsigned s[$]);
        int i;
        byte unsigned b;
        int op;
        int addr;
        int len;
        exp_cmd.delete();
        exp_pl.delete();
        exp_errop = 0;
        i = 0;
        while (i + 6 <= s.size()) begin
            b    = s[i];
            op   = b % 4;
            addr = (s[i+2] * 256 + s[i+3]) % (1 << AW);
            len  = s[i+4] * 256 + s[i+5];
            i += 6;
            if (op == 0) begin
                exp_errop++;
            end else begin
                exp_cmd.push_back({2'(op), 16'(addr), 16'(len)});
                if (op == 1) begin
                    for (int k = 0; k < len; k++) begin
                        exp_pl.push_back(s[i]);
                        i++;
                    end
                end
            end
        end
        exp_pops = i;
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        int n = 0;
        int idle = 0;
        while (idle < 3) begin
            tick();
            n++;
            if (fifo.size() == 0 && !busy && !pl_valid && !cmd_valid) idle++;
            else idle = 0;
            if (n >= budget) begin
                check({tag, ":idle_budget"}, 64'(n), 64'(budget + 1));
                break;
            end
        end
    endtask

    task automatic compare(input string tag);
        check({tag, ":ncmd"}, 64'(obs_cmd.size()), 64'(exp_cmd.size()));
        for (int i = 0; i < exp_cmd.size() && i < obs_cmd.size(); i++)
            check({tag, ":cmd"}, 64'(obs_cmd[i]), 64'(exp_cmd[i]));
        check({tag, ":npl"}, 64'(obs_pl.size()), 64'(exp_pl.size()));
        for (int i = 0; i < exp_pl.size() && i < obs_pl.size(); i++)
            check({tag, ":pl"}, 64'(obs_pl[i]), 64'(exp_pl[i]));
        check({tag, ":errop"}, 64'(n_errop), 64'(exp_errop));
        check({tag, ":errto"}, 64'(n_errto), 64'(0));
        check({tag, ":pops"}, 64'(n_pop), 64'(exp_pops));
        check({tag, ":protocol"}, 64'(viol_rd + viol_cmd + viol_pl), 64'(0));
        check({tag, ":echo"}, 64'(viol_echo), 64'(0));
    endtask

    task automatic run_stream(input string tag, input byte unsigned s[$], input bit gaps);
        int idx = 0;
        model(s);
        clear_obs();
        if (!gaps) begin
            foreach (s[i]) fifo.push_back(s[i]);
        end else begin
            while (idx < s.size()) begin
                int k = $urandom_range(1, 8);
                for (int j = 0; j < k && idx < s.size(); j++) begin
                    fifo.push_back(s[idx]);
                    idx++;
                end
                repeat ($urandom_range(0, 12)) tick();
            end
        end
        run_until_idle(tag, 5000);
        compare(tag);
    endtask

    task automatic rand_run(input int nframes);
        byte unsigned s[$];
        int sel;
        int op;
        int len;
        for (int f = 0; f < nframes; f++) begin
            sel = $urandom_range(0, 9);
            op  = (sel == 0) ? 0 : (sel <= 4) ? 1 : (sel <= 7) ? 2 : 3;
            s.push_back(8'(($urandom_range(0, 63) << 2) | op));
            s.push_back(8'($urandom));
            s.push_back(8'($urandom));
            s.push_back(8'($urandom));
            len = (op == 1) ? $urandom_range(0, 4) : $urandom_range(0, 65535);
            s.push_back(8'(len >> 8));
            s.push_back(8'(len));
            if (op == 1)
                for (int k = 0; k < len; k++) s.push_back(8'($urandom));
        end
        run_stream("rand", s, 1);
    endtask

    initial begin
        byte unsigned s[$];
        rst = 1'b1;
        fifo.delete();
        pop_pending = 0;
        in_empty = 1'b1; in_data = 8'h00; cmd_ready = 1'b0; pl_ready = 1'b0;
        #1;
        check("reset_outputs", {in_read, cmd_valid, cmd_op, 16'(cmd_addr), cmd_len, pl_valid,
               pl_data, echo_valid, echo_data, err_opcode, err_timeout, busy}, 64'(0));
        clear_obs();
        repeat (3) tick();
        rst = 1'b0;

        // Dump command, no payload expected.
        s = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h10};
        run_stream("dump", s, 0);
        check("dump:pl_never", 64'(n_plhigh), 64'(0));

        // Load of two bytes with downstream stalling five cycles per byte.
        pl_mode = 1;
        s = '{8'h01, 8'h00, 8'h00, 8'h20, 8'h00, 8'h02, 8'hAA, 8'hBB};
        run_stream("load2", s, 0);
        check("load2:busy_after_last", 64'(busy_after_pl), 64'(0));
        pl_mode = 0;

        // Bad opcode frame followed by an exec.
        s = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h03, 8'h00, 8'h12, 8'h34, 8'hBE, 8'hEF};
        run_stream("badop_exec", s, 0);

        // Address truncation to ADDR_WIDTH bits.
        s = '{8'h02, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h01};
        run_stream("addr_trunc", s, 0);

        // Zero-length load returns straight to header collection.
        s = '{8'h01, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h09, 8'h00, 8'h03};
        run_stream("load0", s, 0);

        // Partial header abandoned by timeout.
        clear_obs();
        fifo.push_back(8'h02); fifo.push_back(8'h00); fifo.push_back(8'h01);
        repeat (60) tick();
        check("to:early", 64'(n_errto), 64'(0));
        check("to:busy_partial", 64'(busy), 64'(1));
        repeat (60) tick();
        check("to:pulse", 64'(n_errto), 64'(1));
        check("to:busy_after", 64'(busy), 64'(0));
        s = '{8'h02, 8'h00, 8'h00, 8'h05, 8'h00, 8'h01};
        run_stream("to_after", s, 0);

        // Reset in the middle of a payload.
        pl_pct = 0;
        clear_obs();
        s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
        foreach (s[i]) fifo.push_back(s[i]);
        for (int n = 0; n < 50 && !pl_valid; n++) tick();
        check("rst:pl_before", 64'(pl_valid), 64'(1));
        check("rst:first_byte", 64'(pl_data), 64'(8'h11));
        rst = 1'b1;
        #1;
        check("rst:outputs", {in_read, cmd_valid, cmd_op, 16'(cmd_addr), cmd_len, pl_valid,
               pl_data, echo_valid, echo_data, err_opcode, err_timeout, busy}, 64'(0));
        fifo.delete();
        pop_pending = 0;
        clear_obs();
        repeat (3) tick();
        rst = 1'b0;
        pl_pct = 100;
        s = '{8'h03, 8'h00, 8'hAB, 8'hCD, 8'h12, 8'h34};
        run_stream("after_rst", s, 0);

        // Randomized streams with random backpressure and fifo gaps.
        for (int r = 0; r < 6; r++) begin
            cmd_pct = $urandom_range(30, 100);
            pl_pct  = $urandom_range(30, 100);
            rand_run(12);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmd_framer.md
CMD_FRAMER -- requirements
Module: cmd_framer

Interface
REQ-001 Parameter ADDR_WIDTH, default 13, SHALL set the width of cmd_addr (low-memory address space).
REQ-002 Parameter TIMEOUT_CYCLES, default 12000 (1 ms at 12 MHz), SHALL set the inter-byte header timeout; range 1..65535.
REQ-003 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_data  input  8  head byte of the upstream receive fifo, valid while in_empty is low.
REQ-006 in_empty  input  1  upstream fifo empty flag.
REQ-007 in_read  output  1  one-cycle pop strobe to the upstream fifo.
REQ-008 cmd_valid / cmd_ready  output / input  1 / 1  command handshake to the monitor.
REQ-009 cmd_op  output  2  opcode: 1 load, 2 dump, 3 exec.
REQ-010 cmd_addr  output  ADDR_WIDTH  start address.
REQ-011 cmd_len  output  16  length (load/dump) or exec word.
REQ-012 pl_valid / pl_ready / pl_data  output / input / output  1 / 1 / 8  load-payload byte handshake.
REQ-013 echo_valid / echo_data  output / output  1 / 8  echo of every consumed byte.
REQ-014 err_opcode, err_timeout  output  1 each  one-cycle error pulses.
REQ-015 busy  output  1  high whenever not idle (HDR with zero bytes collected).

Function
REQ-016 Header SHALL be 6 bytes: cmd, adr1 (ignored), adr2, adr3, len1, len2; cmd_addr = {adr2,adr3} truncated to ADDR_WIDTH LSBs; cmd_len = {len1,len2}; cmd_op = cmd[1:0].
REQ-017 States: HDR (collect header), SETTLE (one dead cycle after each pop), CMD (present command), PAYLOAD (forward load bytes).
REQ-018 A byte SHALL be consumed only when in_empty is low and the previous cycle had no in_read; in_read and the byte capture SHALL occur in the same cycle, so in_read is never high in two consecutive cycles.
REQ-019 After the 6th header byte the block SHALL enter CMD; cmd_valid SHALL rise the cycle after the SETTLE cycle and hold, with stable cmd_* fields, until a cycle where cmd_ready is high.
REQ-020 On cmd handshake: op 1 with cmd_len != 0 -> PAYLOAD with remaining = cmd_len; otherwise -> HDR with count 0.
REQ-021 cmd[1:0] == 0 SHALL discard the header, pulse err_opcode once, assert no cmd_valid, and return to HDR.
REQ-022 PAYLOAD: when pl_valid is low and a byte is consumable (REQ-018), pl_data <= in_data, pl_valid <= 1, in_read pulses; no further pop while pl_valid is high.
REQ-023 On pl_valid & pl_ready: pl_valid <= 0, remaining decrements; remaining reaching 0 SHALL return to HDR.
REQ-024 Timeout: in HDR with 1..5 bytes collected, TIMEOUT_CYCLES consecutive cycles without a pop SHALL discard the partial header, pulse err_timeout, and reset the count to 0; payload and CMD never time out.
REQ-025 Bytes arriving while in CMD SHALL remain in the upstream fifo (no pop).

Reset
REQ-026 rst asserted SHALL immediately force state HDR, count 0, remaining 0, timer 0, and every output low (data outputs 0x00), regardless of state, including mid-payload.
REQ-027 After rst deasserts the next byte consumed SHALL be treated as header byte 0.

Configuration
REQ-028 Macro CMD_FRAMER_ECHO_EN defined: echo_valid SHALL pulse with echo_data = the consumed byte in the same cycle as every in_read (header and payload).
REQ-029 CMD_FRAMER_ECHO_EN undefined: echo_valid and echo_data SHALL be constant 0; ports remain present.

Verification
REQ-030 Feed 02 00 01 00 00 10, cmd_ready=1 -> one cmd handshake op=2 addr=0x0100 len=0x0010; pl_valid never high.
REQ-031 Feed 01 00 00 20 00 02 AA BB, pl_ready low 5 cycles per byte -> cmd op=1 addr=0x020 len=2, then pl_data AA then BB, exactly 8 in_read pulses, busy low after BB accepted.
REQ-032 Feed 00 11 22 33 44 55 then 03 00 12 34 BE EF -> one err_opcode pulse, then cmd op=3 addr=0x1234 len=0xBEEF.
REQ-033 TIMEOUT_CYCLES=100: feed 02 00 01, idle 100 cycles -> err_timeout pulse; then 02 00 00 05 00 01 -> cmd addr=0x0005 len=1.
REQ-034 Header 02 00 FF FF 00 01 with ADDR_WIDTH=13 -> cmd_addr=0x1FFF.
REQ-035 Assert rst after first payload byte of a len=4 load -> all outputs 0 same cycle; next header parsed correctly; with CMD_FRAMER_ECHO_EN, echo count equals in_read count.
